// File: rtl/gpu_out_fifo.sv
// Output buffer for the GPU debug/print stream, drained by the host over valid/ready.
// Define GPU_OUT_FIFO_TIMESTAMP_EN to tag each entry with a free-running cycle count (rd_ts).
module gpu_out_fifo #(
    parameter int unsigned data_width = 32,
    parameter int unsigned depth      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_en,
    input  logic                         in_flen,
    input  logic [data_width-1:0]        in_data,
    input  logic                         halt,
    input  logic                         clr,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [data_width-1:0]        rd_data,
    output logic                         rd_flen,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         overflow,
    output logic                         done
`ifdef GPU_OUT_FIFO_TIMESTAMP_EN
    ,
    output logic [31:0]                  rd_ts
`endif
);

    localparam int unsigned aw = $clog2(depth);
    localparam int unsigned cw = $clog2(depth + 1);
`ifdef GPU_OUT_FIFO_TIMESTAMP_EN
    localparam int unsigned ew = data_width + 1 + 32;
`else
    localparam int unsigned ew = data_width + 1;
`endif
    localparam logic [aw:0]   ptr_one = 1;
    localparam logic [cw-1:0] cnt_one = 1;

    logic [ew-1:0]   mem_q [depth];
    logic [ew-1:0]   wr_entry;
    logic [ew-1:0]   head;
    logic [aw:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cw-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            halt_seen_q, halt_seen_d;
    logic            done_q, done_d;
    logic            full, empty, do_pop, do_push, wr_en;

`ifdef GPU_OUT_FIFO_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_q <= '0;
        else      ts_q <= ts_q + 32'd1;
    end

    assign wr_entry = {ts_q, in_flen, in_data};
    assign rd_ts    = head[ew-1 -: 32];
`else
    assign wr_entry = {in_flen, in_data};
`endif

    assign full  = (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]) && (wr_ptr_q[aw] != rd_ptr_q[aw]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_pop  = !empty && rd_ready;
    assign do_push = in_en && (!full || do_pop);
    assign wr_en   = do_push && !clr;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        halt_seen_d = halt_seen_q || halt;
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            halt_seen_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ptr_one;
            if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_one;
            if (do_push && !do_pop)      count_d = count_q + cnt_one;
            else if (do_pop && !do_push) count_d = count_q - cnt_one;
            if (in_en && full && !do_pop) overflow_d = 1'b1;
        end
        done_d = halt_seen_d && (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            halt_seen_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            halt_seen_q <= halt_seen_d;
            done_q      <= done_d;
        end
    end

    // Storage is reset so the stale head reads as zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(depth); i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q[aw-1:0]] <= wr_entry;
        end
    end

    assign head     = mem_q[rd_ptr_q[aw-1:0]];
    assign rd_valid = !empty;
    assign rd_data  = head[data_width-1:0];
    assign rd_flen  = head[data_width];
    assign count    = count_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule

// File: tb/tb_gpu_out_fifo.sv
// Scoreboard bench for gpu_out_fifo: directed pushes queue expected words, a negedge
// monitor checks every accepted pop; occupancy/flag checks run inline.
module tb_gpu_out_fifo;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 16;

    logic          clk = 1'b0;
    logic          rst, in_en, in_flen, halt, clr, rd_ready;
    logic [DW-1:0] in_data;
    logic          rd_valid, rd_flen, overflow, done;
    logic [DW-1:0] rd_data;
    logic [4:0]    count;
`ifdef GPU_OUT_FIFO_TIMESTAMP_EN
    logic [31:0]   rd_ts;
`endif

    int passed = 0;
    int total  = 0;
    logic [DW:0] sb [$];

    gpu_out_fifo #(.data_width(DW), .depth(DP)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_flen(in_flen), .in_data(in_data),
        .halt(halt), .clr(clr), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_flen(rd_flen), .count(count), .overflow(overflow),
        .done(done)
`ifdef GPU_OUT_FIFO_TIMESTAMP_EN
        , .rd_ts(rd_ts)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic f, input bit keep);
        in_en   = 1'b1;
        in_data = d;
        in_flen = f;
        if (keep) sb.push_back({f, d});
        tick();
        in_en = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) tick();
        rd_ready = 1'b0;
    endtask

    // Monitor: a pop happens on the next posedge whenever valid && ready now.
    always @(negedge clk) begin
        if (rst && rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", {31'd0, rd_flen, rd_data}, 64'hdead);
            end else begin
                logic [DW:0] e;
                e = sb.pop_front();
                check("pop_data", {32'd0, rd_data}, {32'd0, e[DW-1:0]});
                check("pop_flen", {63'd0, rd_flen}, {63'd0, e[DW]});
            end
        end
    end

    initial begin
        rst = 1'b0; in_en = 1'b0; in_flen = 1'b0; in_data = '0;
        halt = 1'b0; clr = 1'b0; rd_ready = 1'b0;
        #12;
        check("rst_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_data", {32'd0, rd_data}, 64'd0);
        check("rst_count", {59'd0, count}, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b1;
        tick();

        // Basic three-word push then drain.
        push(32'h11, 1'b0, 1'b1);
        push(32'h22, 1'b0, 1'b1);
        push(32'h33, 1'b1, 1'b1);
        check("t1_count", {59'd0, count}, 64'd3);
        check("t1_valid", {63'd0, rd_valid}, 64'd1);
        check("t1_head", {32'd0, rd_data}, 64'h11);
        check("t1_flen", {63'd0, rd_flen}, 64'd0);
        drain(3);
        check("t1_count_end", {59'd0, count}, 64'd0);
        check("t1_valid_end", {63'd0, rd_valid}, 64'd0);

        // Overflow: 17 pushes into depth 16, last word lost.
        for (int i = 0; i < 17; i++) push(i, 1'b0, i < 16);
        check("t2_count", {59'd0, count}, 64'd16);
        check("t2_ovf", {63'd0, overflow}, 64'd1);
        drain(16);
        check("t2_count_end", {59'd0, count}, 64'd0);
        check("t2_ovf_sticky", {63'd0, overflow}, 64'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("t2_ovf_clr", {63'd0, overflow}, 64'd0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 16; i++) push(32'h100 + i, 1'b0, 1'b1);
        rd_ready = 1'b1;
        push(32'hAA, 1'b1, 1'b1);
        rd_ready = 1'b0;
        check("t3_count", {59'd0, count}, 64'd16);
        check("t3_ovf", {63'd0, overflow}, 64'd0);
        drain(16);
        check("t3_count_end", {59'd0, count}, 64'd0);

        // Halt then drain: done follows the last pop.
        push(32'h5, 1'b0, 1'b1);
        push(32'h6, 1'b0, 1'b1);
        halt = 1'b1; tick(); halt = 1'b0;
        check("t4_done_pre", {63'd0, done}, 64'd0);
        rd_ready = 1'b1;
        tick();
        check("t4_done_mid", {63'd0, done}, 64'd0);
        tick();
        rd_ready = 1'b0;
        check("t4_done", {63'd0, done}, 64'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("t4_done_clr", {63'd0, done}, 64'd0);
        check("t4_count_clr", {59'd0, count}, 64'd0);
        tick();
        check("t4_done_stays", {63'd0, done}, 64'd0);

        // Streaming: 40 words with ready held high, pointers wrap twice.
        rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(32'h1000 + i, i[0], 1'b1);
            check("t5_count_le1", {63'd0, count <= 5'd1}, 64'd1);
        end
        tick();
        rd_ready = 1'b0;
        check("t5_count_end", {59'd0, count}, 64'd0);
        check("t5_ovf", {63'd0, overflow}, 64'd0);
        check("t5_done", {63'd0, done}, 64'd0);

        // Asynchronous reset between edges.
        for (int i = 0; i < 5; i++) push(32'h77 + i, 1'b0, 1'b0);
        check("t6_count", {59'd0, count}, 64'd5);
        #2;
        rst = 1'b0;
        #1;
        check("t6_count_rst", {59'd0, count}, 64'd0);
        check("t6_valid_rst", {63'd0, rd_valid}, 64'd0);
        check("t6_data_rst", {32'd0, rd_data}, 64'd0);
        #4;
        rst = 1'b1;

`ifdef GPU_OUT_FIFO_TIMESTAMP_EN
        // Counter is 0 at release; the 4th edge samples 3, the 8th samples 7.
        repeat (3) tick();
        push(32'hE1, 1'b0, 1'b1);
        repeat (3) tick();
        push(32'hE2, 1'b0, 1'b1);
        check("ts_first", {32'd0, rd_ts}, 64'd3);
        drain(1);
        check("ts_second", {32'd0, rd_ts}, 64'd7);
        drain(1);
`endif

        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gpu_out_fifo.md
Name: gpu_out_fifo

Overview:
Downstream stage of the GPU card that captures the GPU's debug/print output stream (out, outen, outflen) into a buffer. Sits between the GPU card's output pins and the host-side reader, so the GPU never stalls on the host. Entries drain over a valid/ready handshake. The block tracks overflow and end-of-program (halt) so the host knows when all output has been consumed.

Parameters:
data_width, 32, width of each output word (matches GPU out bus)
depth, 16, number of buffered entries; power of two, >= 2

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low
in_en  input  1  GPU output strobe (connects to outen)
in_flen  input  1  word is float-formatted (connects to outflen)
in_data  input  data_width  GPU output word (connects to out)
halt  input  1  GPU halt level from gpu_card
clr  input  1  synchronous flush: empties FIFO, clears overflow and done
rd_ready  input  1  host accepts head entry
rd_valid  output  1  head entry valid
rd_data  output  data_width  head entry data
rd_flen  output  1  head entry float flag
count  output  $clog2(depth+1)  current occupancy
overflow  output  1  sticky: at least one word dropped
done  output  1  halt seen and FIFO empty

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on port rst; with rst=0 all state clears immediately.
- Reset values: rd_valid=0, rd_data=0, rd_flen=0, count=0, overflow=0, done=0. Pointers=0, halt_seen=0.
- Storage is a circular buffer of {in_flen, in_data}, with read and write pointers of $clog2(depth) bits plus one wrap bit each.
- Full is pointer bits equal with wrap bits differing. Empty is full pointers equal.
- Push: on a rising clk edge with in_en=1, the word is written at wr_ptr and wr_ptr increments, wrapping depth-1 to 0 and toggling the wrap bit.
- Pop: occurs on a rising clk edge with rd_valid=1 and rd_ready=1; rd_ptr increments.
- rd_valid, rd_data and rd_flen are combinational from the head entry. rd_valid equals !empty.
- Latency: a word pushed at edge N is visible on rd_* after edge N, so it can pop at edge N+1.
- When not valid, rd_data and rd_flen hold the stale head contents. The host must ignore them.
- count is updated on the same edge as push/pop: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full, with push and pop in the same cycle: the push is accepted and count stays at depth.
- Full, push without pop: the word is dropped, pointers are unchanged, and overflow is set to 1.
- overflow is sticky until clr or reset.
- Empty with rd_ready=1: nothing happens; rd_valid stays 0.
- Empty with push and rd_ready in the same cycle: only the push occurs, because rd_valid was 0 that cycle.
- halt_seen is set on any edge with halt=1 and stays set until clr or reset.
- done is registered: done <= halt_seen_next && (count_next == 0). It asserts one edge after the last pop that follows halt, or one edge after halt if the FIFO is already empty.
- in_en in the same cycle as halt=1 is still accepted.
- clr=1 takes priority over push and pop. On the next edge: pointers=0, count=0, overflow=0, halt_seen=0, done=0, and the input word is discarded.
- rst deasserted mid-stream: the FIFO restarts empty. No partial entries survive.

Optional Feature:
GPU_OUT_FIFO_TIMESTAMP_EN
- Defined: adds a 32-bit free-running cycle counter (reset 0, increments every clk, wraps at 2^32-1 to 0).
  - Each pushed entry also stores the counter value at its push edge.
  - Adds output port rd_ts (32 bits), head entry timestamp, reset value 0.
  - Dropped words do not consume timestamps in storage.
- Undefined: no counter, no rd_ts port, and storage width is data_width+1.

Test Plan:
- Reset, then push 3 words (0x11, 0x22, 0x33 float) with rd_ready=0 -> count=3, rd_valid=1, rd_data=0x11, rd_flen=0. Then hold rd_ready=1 for 3 cycles -> pops 0x11, 0x22, 0x33 (rd_flen=1 on the third), count=0, rd_valid=0.
- depth=16: push 17 words 0..16 with rd_ready=0 -> count=16, overflow=1. Draining yields 0..15; word 16 is lost.
- Fill to 16, then apply push 0xAA and pop together -> count stays 16, overflow=0. 0xAA is read after the 15 remaining older words.
- Push 2 words, pulse halt, then drain -> done=0 until the edge after the second pop, then done=1. A subsequent clr -> done=0, overflow=0, count=0.
- Push 40 words while popping every cycle (rd_ready=1) -> all 40 are received in order, pointers wrap twice, overflow=0, count never exceeds 1.
- Assert rst=0 asynchronously between clock edges while count=5 -> count=0 and rd_valid=0 immediately, before the next edge. With GPU_OUT_FIFO_TIMESTAMP_EN: push at cycles 3 and 7 after reset -> rd_ts reads 3 then 7.
